// File: rtl/xyolo_int_addrgen.sv
// -----------------------------------------------------------------------------
// xyolo_int_addrgen
//
// Internal (B-side) sequencer for the YOLO write stage. On a run pulse it
// latches its configuration, then issues one pixel read per cycle to the vread
// memory together with the matching weight tap index. The read strobe is
// delayed to produce the xyolo vector controls (ld_acc, ld_res, ld_mp), and
// ld_res is delayed again to produce the vwrite memory writes once each result
// is stable at the xyolo output.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   run             start pulse, accepted only while idle
//   done            high while idle (nothing in flight)
//   start/incr/shift  pixel address start, per-tap step, extra per-output step
//   period          taps per output; iterations: number of outputs
//   out_start       first vwrite address
//   maxpool         2x2 maxpool mode: one write per group of 4 results
//   vwrite_mask     lanes written on each vwrite
//   vread_enB/vread_addrB  pixel read strobe and address
//   w_en/w_addr     weight fetch strobe and tap index
//   ld_acc/ld_mp/ld_res    xyolo vector controls
//   vwrite_enB/vwrite_addrB  per-lane write enables and write address
//   dbg_state       current FSM state (IDLE=0, ISSUE=1, DRAIN=2)
//
// Latency from run accept to done high:
//   iterations*period + RD_LAT + 1 + XY_LAT + 2 cycles.
// -----------------------------------------------------------------------------
module xyolo_int_addrgen #(
   parameter int N_VECT  = 16,
   parameter int RADDR_W = 14,
   parameter int WADDR_W = 10,
   parameter int CNT_W   = 16,
   parameter int RD_LAT  = 2,
   parameter int XY_LAT  = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic               done,
   input  logic [RADDR_W-1:0] start,
   input  logic [RADDR_W-1:0] incr,
   input  logic [RADDR_W-1:0] shift,
   input  logic [CNT_W-1:0]   period,
   input  logic [CNT_W-1:0]   iterations,
   input  logic [WADDR_W-1:0] out_start,
   input  logic               maxpool,
   input  logic [N_VECT-1:0]  vwrite_mask,
   output logic               vread_enB,
   output logic [RADDR_W-1:0] vread_addrB,
   output logic               w_en,
   output logic [CNT_W-1:0]   w_addr,
   output logic               ld_acc,
   output logic               ld_mp,
   output logic               ld_res,
   output logic [N_VECT-1:0]  vwrite_enB,
   output logic [WADDR_W-1:0] vwrite_addrB,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0]   C_ONE = CNT_W'(1);
   localparam logic [WADDR_W-1:0] W_ONE = WADDR_W'(1);

   state_t r_state, w_state_nxt;

   // latched configuration
   logic [RADDR_W-1:0] r_incr, r_shift;
   logic [CNT_W-1:0]   r_period, r_iter;
   logic               r_mp;
   logic [N_VECT-1:0]  r_mask;

   // issue-side counters
   logic [RADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]   r_tap, r_out_cnt;

   // write-side counters
   logic [WADDR_W-1:0] r_wptr;
   logic [CNT_W-1:0]   r_res_cnt;
   logic [1:0]         r_grp_cnt;

   // delay lines: read strobe, last-tap strobe, result-to-write
   logic [RD_LAT-1:0]  r_rd_pipe;
   logic [RD_LAT:0]    r_last_pipe;
   logic [XY_LAT-1:0]  r_wr_pipe;

   logic w_accept, w_issue, w_last_tap, w_last_out, w_pipe_empty;
   logic w_wr_pulse, w_write;

   assign w_issue      = (r_state == S_ISSUE);
   assign w_last_tap   = (r_tap == r_period - C_ONE);
   assign w_last_out   = (r_out_cnt == r_iter - C_ONE);
   assign w_pipe_empty = ~|r_rd_pipe & ~|r_last_pipe & ~|r_wr_pipe;
   assign w_wr_pulse   = r_wr_pipe[XY_LAT-1];
   // In maxpool mode only every 4th result is written, except that the final
   // result always flushes a trailing partial group.
   assign w_write      = w_wr_pulse &
                         (~r_mp | (r_grp_cnt == 2'd3) | (r_res_cnt == r_iter - C_ONE));

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (run) begin
               w_accept = 1'b1;
               // a zero-sized job latches config but never leaves idle
               if ((iterations != '0) && (period != '0)) w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (w_last_tap && w_last_out) w_state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            if (w_pipe_empty) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // configuration capture and read address / tap sequencing
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_incr    <= '0;
         r_shift   <= '0;
         r_period  <= '0;
         r_iter    <= '0;
         r_mp      <= 1'b0;
         r_mask    <= '0;
         r_addr    <= '0;
         r_tap     <= '0;
         r_out_cnt <= '0;
      end else if (w_accept) begin
         r_incr    <= incr;
         r_shift   <= shift;
         r_period  <= period;
         r_iter    <= iterations;
         r_mp      <= maxpool;
         r_mask    <= vwrite_mask;
         r_addr    <= start;
         r_tap     <= '0;
         r_out_cnt <= '0;
      end else if (w_issue) begin
         if (w_last_tap) begin
            r_addr    <= r_addr + r_incr + r_shift;
            r_tap     <= '0;
            r_out_cnt <= r_out_cnt + C_ONE;
         end else begin
            r_addr <= r_addr + r_incr;
            r_tap  <= r_tap + C_ONE;
         end
      end
   end

   // delay lines
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rd_pipe   <= '0;
         r_last_pipe <= '0;
         r_wr_pipe   <= '0;
      end else begin
         r_rd_pipe[0]   <= w_issue;
         r_last_pipe[0] <= w_issue & w_last_tap;
         r_wr_pipe[0]   <= r_last_pipe[RD_LAT];
         for (int k = 1; k < RD_LAT; k++)  r_rd_pipe[k]   <= r_rd_pipe[k-1];
         for (int k = 1; k <= RD_LAT; k++) r_last_pipe[k] <= r_last_pipe[k-1];
         for (int k = 1; k < XY_LAT; k++)  r_wr_pipe[k]   <= r_wr_pipe[k-1];
      end
   end

   // write pointer and result counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr    <= '0;
         r_res_cnt <= '0;
         r_grp_cnt <= '0;
      end else if (w_accept) begin
         r_wptr    <= out_start;
         r_res_cnt <= '0;
         r_grp_cnt <= '0;
      end else if (w_wr_pulse) begin
         r_res_cnt <= r_res_cnt + C_ONE;
         r_grp_cnt <= r_grp_cnt + 2'd1;
         if (w_write) r_wptr <= r_wptr + W_ONE;
      end
   end

   assign done         = (r_state == S_IDLE);
   assign vread_enB    = w_issue;
   assign w_en         = w_issue;
   assign vread_addrB  = w_issue ? r_addr : '0;
   assign w_addr       = w_issue ? r_tap : '0;
   assign ld_acc       = r_rd_pipe[RD_LAT-1];
   assign ld_res       = r_last_pipe[RD_LAT];
   assign ld_mp        = r_last_pipe[RD_LAT] & r_mp;
   assign vwrite_enB   = w_write ? r_mask : '0;
   assign vwrite_addrB = w_write ? r_wptr : '0;
   assign dbg_state    = r_state;

endmodule

// File: doc/xyolo_int_addrgen.md
Name: xyolo_int_addrgen

Overview:
- Internal sequencer that drives the B-side (internal) ports of the YOLO write stage.
- Generates the pixel read addresses for the vread memory and the weight tap index for the weight/bias stage.
- Produces the ld_acc/ld_mp/ld_res controls to the xyolo vector, aligned to the read pipeline.
- Issues vwrite memory writes once each result is stable. Starts on global run; its done is ANDed with the stage's external addrgen done.

Parameters:
N_VECT, 16, number of xyolo lanes (width of vwrite_enB)
RADDR_W, 14, vread memory read address width (PIXEL_ADDR_W)
WADDR_W, 10, vwrite memory address width (VWRITE_ADDR_W)
CNT_W, 16, iteration/period counter width
RD_LAT, 2, cycles from vread_enB to pixel valid at xyolo input (mem read + output register)
XY_LAT, 3, cycles from ld_res to valid xyolo flow_out

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  start pulse (global_run)
done  out  1  high when idle and pipeline drained
start  in  RADDR_W  first pixel read address
incr  in  RADDR_W  address step between taps
shift  in  RADDR_W  extra address step applied after the last tap of an output
period  in  CNT_W  taps per output (MACs per result)
iterations  in  CNT_W  number of outputs
out_start  in  WADDR_W  first vwrite address
maxpool  in  1  2x2 maxpool mode: 4 results per write
vwrite_mask  in  N_VECT  lanes enabled for write
vread_enB  out  1  pixel read enable
vread_addrB  out  RADDR_W  pixel read address
w_en  out  1  weight fetch enable, same cycle as vread_enB
w_addr  out  CNT_W  tap index 0..period-1
ld_acc  out  1  accumulate current pixel*weight
ld_mp  out  1  load maxpool register
ld_res  out  1  load result register
vwrite_enB  out  N_VECT  per-lane vwrite memory write enable
vwrite_addrB  out  WADDR_W  vwrite memory write address

Behaviour:
Reset values:
- All outputs 0, except done=1.
- State IDLE; counters and delay lines cleared.

IDLE:
- run=1 latches all config inputs into registers.
- If iterations==0 or period==0: done stays 1, no activity.
- Otherwise go to ISSUE; done=0 from the next cycle.
- Config inputs are ignored outside IDLE. run while not IDLE is ignored.

ISSUE:
- One read per cycle: vread_enB=w_en=1, vread_addrB=addr, w_addr=tap.
- tap counts 0..period-1. Non-last tap: addr += incr.
- Last tap: addr += incr + shift, tap←0, out_cnt+1.
- After the last tap of output iterations-1: go to DRAIN.
- Address arithmetic wraps modulo 2^RADDR_W.

Delay line (RD_LAT deep, shift register):
- ld_acc = vread_enB delayed RD_LAT cycles.
- ld_res = (vread_enB & last tap) delayed RD_LAT+1 cycles, i.e. the cycle after the final ld_acc of that output.
- ld_mp = ld_res when maxpool=1, else 0.

Write path:
- wr_pulse = ld_res delayed XY_LAT cycles.
- maxpool=0: every wr_pulse writes.
- maxpool=1: a 2-bit result counter advances per wr_pulse; the write occurs on every 4th pulse (count 3). A trailing partial group (iterations not a multiple of 4) is still written on the last result.
- On a write: vwrite_enB=vwrite_mask, vwrite_addrB=wptr. wptr starts at out_start, +1 after each write, wraps modulo 2^WADDR_W.
- vwrite_enB is 0 on all non-write cycles.

DRAIN:
- No reads are issued.
- When the final write has issued and all delay lines are empty, go to IDLE; done=1 in the following cycle.
- Total latency run→done = iterations*period + RD_LAT + 1 + XY_LAT + 2 cycles.

Reset asserted mid-operation: immediate return to IDLE with reset values; no further writes.

Back-to-back operation: a run arriving on the cycle done rises is accepted.

Test Plan:
- start=100, incr=1, shift=0, period=3, iterations=2, out_start=5, maxpool=0, mask=all ones, run → reads at 100..105; ld_acc 2 cycles after each read; ld_res pulses at cycles 6 and 9 after run accept; vwrite_enB=0xFFFF at addr 5 then 6, 3 cycles after each ld_res; done rises after drain.
- period=2, incr=2, shift=10 from start=0 → addresses 0,2,14,16,28,30; w_addr 0,1,0,1,0,1.
- maxpool=1, period=1, iterations=8 → ld_mp on all 8 results; exactly 2 writes, at out_start and out_start+1, each on the 4th result of its group.
- iterations=0 with run → done never drops; all enables stay 0.
- Reset low mid-ISSUE → next edge: all outputs 0, done=1; second run restarts from the newly latched start.
- start=0x3FFF, incr=1, out_start=0x3FF → read address wraps to 0; write address wraps to 0 on the second write.
